bfly_stage_ctrl: RTL and testbench

Sequencer for one radix-2 DIF stage of the pipelined FFT. It buffers the first half of every 2·SPAN-sample block and pairs each held sample with its partner in the second half. Each pair, together with a twiddle coefficient from a writable coefficient table, goes to an external hardware butterfly (sum / difference·coef, fixed latency, aux pass-through). Butterfly results are re-serialised into a single output stream for the next stage.

---
 rtl/bfly_stage_ctrl_if.sv | 23 ++
 rtl/bfly_stage_ctrl.sv | 91 +++++++++
 tb/tb_bfly_stage_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bfly_stage_ctrl_if.sv
// bfly_stage_ctrl_if: operand/result bus between the stage sequencer and its external butterfly.
interface bfly_stage_ctrl_if #(
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 20,
  parameter int OWIDTH = 17
);
  logic                  o_bf_ce;
  logic [2*IWIDTH-1:0]   o_bf_left;
  logic [2*IWIDTH-1:0]   o_bf_right;
  logic [2*CWIDTH-1:0]   o_bf_coef;
  logic                  o_bf_aux;
  logic [2*OWIDTH-1:0]   i_bf_left;
  logic [2*OWIDTH-1:0]   i_bf_right;
  logic                  i_bf_aux;
  modport master (
    output o_bf_ce, o_bf_left, o_bf_right, o_bf_coef, o_bf_aux,
    input  i_bf_left, i_bf_right, i_bf_aux
  );
  modport slave (
    input  o_bf_ce, o_bf_left, o_bf_right, o_bf_coef, o_bf_aux,
    output i_bf_left, i_bf_right, i_bf_aux
  );
endinterface

// File: rtl/bfly_stage_ctrl.sv
// bfly_stage_ctrl: pairs samples SPAN apart for a radix-2 DIF butterfly and re-serialises its results.
module bfly_stage_ctrl #(
  parameter int IWIDTH = 16,
  parameter int CWIDTH = 20,
  parameter int OWIDTH = 17,
  parameter int LGSPAN = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_ce,
  input  logic [2*IWIDTH-1:0] i_sample,
  input  logic                i_sync,
  input  logic                i_cw_we,
  input  logic [LGSPAN-1:0]   i_cw_addr,
  input  logic [2*CWIDTH-1:0] i_cw_data,
  bfly_stage_ctrl_if.master   bf,
  output logic [2*OWIDTH-1:0] o_sample,
  output logic                o_sync
);
  localparam int SPAN = 1 << LGSPAN;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [LGSPAN:0] iaddr_q, iaddr_d, cur_a;
  logic [LGSPAN-1:0] k;
  logic run, pair;
  logic [2*IWIDTH-1:0] ibuf [SPAN];
  logic [2*CWIDTH-1:0] ctab [SPAN];
  logic [2*OWIDTH-1:0] obuf [SPAN];
  logic [2*IWIDTH-1:0] left_q, right_q;
  logic [2*CWIDTH-1:0] coef_q;
  logic aux_q;
  logic oact_q, olive;
  logic [LGSPAN:0] ocnt_q, ocnt_d, slot;
  logic [2*OWIDTH-1:0] sample_q, sample_d;
  logic sync_q;
  always_comb begin
    state_d  = state_q;
    run      = i_ce && (i_sync || state_q == RUN);
    cur_a    = i_sync ? '0 : iaddr_q;
    k        = cur_a[LGSPAN-1:0];
    pair     = cur_a[LGSPAN];
    iaddr_d  = run ? cur_a + 1'b1 : iaddr_q;
    state_d  = run ? RUN : state_q;
    // a result flagged aux always restarts the output block at slot 0
    slot     = bf.i_bf_aux ? '0 : ocnt_q;
    olive    = i_ce && (oact_q || bf.i_bf_aux);
    ocnt_d   = olive ? slot + 1'b1 : ocnt_q;
    sample_d = slot[LGSPAN] ? obuf[slot[LGSPAN-1:0]] : bf.i_bf_left;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      iaddr_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      coef_q   <= '0;
      aux_q    <= 1'b0;
      oact_q   <= 1'b0;
      ocnt_q   <= '0;
      sample_q <= '0;
      sync_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iaddr_q <= iaddr_d;
      if (run) begin
        left_q  <= ibuf[k];
        right_q <= i_sample;
        coef_q  <= ctab[k];
        aux_q   <= pair && k == '0;
      end
      ocnt_q <= ocnt_d;
      if (olive) begin
        oact_q   <= 1'b1;
        sample_q <= sample_d;
        sync_q   <= bf.i_bf_aux;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (run && !pair && !i_reset) ibuf[k] <= i_sample;
    if (i_cw_we) ctab[i_cw_addr] <= i_cw_data;
    if (olive && !slot[LGSPAN] && !i_reset) obuf[slot[LGSPAN-1:0]] <= bf.i_bf_right;
  end
  assign bf.o_bf_ce    = i_ce;
  assign bf.o_bf_left  = left_q;
  assign bf.o_bf_right = right_q;
  assign bf.o_bf_coef  = coef_q;
  assign bf.o_bf_aux   = aux_q;
  assign o_sample      = sample_q;
  assign o_sync        = sync_q;
endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// tb_bfly_stage_ctrl: directed checks of pairing, streaming, gaps, resync, coef writes and reset.
module tb_bfly_stage_ctrl;
  localparam int IW = 16, CW = 20, OW = 17, LG = 2, L = 6;
  localparam logic [CW-1:0] ONE = 20'h40000;
  logic clk = 1'b0, rst = 1'b1;
  logic i_ce = 1'b0, i_sync = 1'b0, i_cw_we = 1'b0;
  logic [2*IW-1:0] i_sample = '0;
  logic [LG-1:0] i_cw_addr = '0;
  logic [2*CW-1:0] i_cw_data = '0;
  logic [2*OW-1:0] o_sample;
  logic o_sync;
  int n_run = 0, n_fail = 0, hold_viol = 0;
  bit hold_en = 1'b0, ce_q = 1'b0;
  logic [2*OW-1:0] prev_s = '0;
  logic [2*OW-1:0] samp_q [$];
  bit sync_q [$];
  logic [2*OW-1:0] pl [L], pr [L];
  logic pa [L];
  bfly_stage_ctrl_if #(.IWIDTH(IW), .CWIDTH(CW), .OWIDTH(OW)) bf ();
  bfly_stage_ctrl #(.IWIDTH(IW), .CWIDTH(CW), .OWIDTH(OW), .LGSPAN(LG)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce(i_ce), .i_sample(i_sample), .i_sync(i_sync),
    .i_cw_we(i_cw_we), .i_cw_addr(i_cw_addr), .i_cw_data(i_cw_data),
    .bf(bf), .o_sample(o_sample), .o_sync(o_sync)
  );
  always #5 clk = ~clk;
  function automatic logic [2*OW-1:0] mk(int r, int i);
    logic [OW-1:0] a, b;
    a = r[OW-1:0];
    b = i[OW-1:0];
    return {a, b};
  endfunction
  function automatic logic [2*OW-1:0] bsum(logic [2*IW-1:0] a, logic [2*IW-1:0] b);
    return mk(int'($signed(a[31:16])) + int'($signed(b[31:16])),
              int'($signed(a[15:0])) + int'($signed(b[15:0])));
  endfunction
  function automatic logic [2*OW-1:0] bdif(logic [2*IW-1:0] a, logic [2*IW-1:0] b, logic [2*CW-1:0] c);
    longint dr, di, cr, ci;
    dr = longint'($signed(a[31:16])) - longint'($signed(b[31:16]));
    di = longint'($signed(a[15:0])) - longint'($signed(b[15:0]));
    cr = longint'($signed(c[39:20]));
    ci = longint'($signed(c[19:0]));
    return mk(int'((dr * cr - di * ci) >>> 18), int'((dr * ci + di * cr) >>> 18));
  endfunction
  // behavioural butterfly: L-deep pipeline advancing on o_bf_ce
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        pl[i] <= '0; pr[i] <= '0; pa[i] <= 1'b0;
      end
    end else if (bf.o_bf_ce) begin
      pl[0] <= bsum(bf.o_bf_left, bf.o_bf_right);
      pr[0] <= bdif(bf.o_bf_left, bf.o_bf_right, bf.o_bf_coef);
      pa[0] <= bf.o_bf_aux;
      for (int i = 1; i < L; i++) begin
        pl[i] <= pl[i-1]; pr[i] <= pr[i-1]; pa[i] <= pa[i-1];
      end
    end
  end
  assign bf.i_bf_left  = pl[L-1];
  assign bf.i_bf_right = pr[L-1];
  assign bf.i_bf_aux   = pa[L-1];
  always @(posedge clk) ce_q <= i_ce && !rst;
  always @(negedge clk) begin
    if (ce_q) begin
      samp_q.push_back(o_sample);
      sync_q.push_back(o_sync);
    end else if (hold_en && o_sample !== prev_s) hold_viol++;
    prev_s = o_sample;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit ce, input int re, input bit sy);
    i_ce = ce;
    i_sample = {re[15:0], 16'd0};
    i_sync = sy;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    i_ce = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    samp_q.delete();
    sync_q.delete();
  endtask
  task automatic find_sync(input int from, output int idx);
    idx = -1;
    for (int i = from; i < samp_q.size(); i++)
      if (sync_q[i]) begin
        idx = i;
        break;
      end
  endtask
  task automatic check_blk(input string tag, input int first, input int base, input int rot);
    logic [2*OW-1:0] e;
    if (first < 0 || first + 8 > samp_q.size()) begin
      chk({tag, "_len"}, 64'd0, 64'd1);
      return;
    end
    for (int j = 0; j < 8; j++) begin
      e = j < 4 ? mk(base + 2 * j, 0) : (j == rot ? mk(0, -4) : mk(-4, 0));
      chk($sformatf("%s_s%0d", tag, j), 64'(samp_q[first + j]), 64'(e));
      chk($sformatf("%s_y%0d", tag, j), 64'(sync_q[first + j]), 64'(j == 0));
    end
  endtask
  initial begin
    int f, f2, ns;
    #1;
    chk("rst_left", 64'(bf.o_bf_left), 64'd0);
    chk("rst_aux", 64'(bf.o_bf_aux), 64'd0);
    chk("rst_sample", 64'(o_sample), 64'd0);
    chk("rst_sync", 64'(o_sync), 64'd0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      i_cw_we = 1'b1; i_cw_addr = 2'(i); i_cw_data = {ONE, 20'd0};
      step(0, 0, 0);
    end
    i_cw_we = 1'b0;
    // continuous stream of three blocks
    for (int b = 0; b < 3; b++)
      for (int v = 1; v <= 8; v++) begin
        step(1, v, b == 0 && v == 1);
        if (b == 0 && v == 5) begin
          chk("pair0_aux", 64'(bf.o_bf_aux), 64'd1);
          chk("pair0_left", 64'(bf.o_bf_left), 64'h0001_0000);
          chk("pair0_right", 64'(bf.o_bf_right), 64'h0005_0000);
          chk("pair0_coef", 64'(bf.o_bf_coef), 64'({ONE, 20'd0}));
        end
        if (b == 0 && v == 6) chk("pair1_aux", 64'(bf.o_bf_aux), 64'd0);
      end
    repeat (20) step(1, 0, 0);
    find_sync(0, f);
    for (int b = 0; b < 3; b++) check_blk($sformatf("cont_b%0d", b), f < 0 ? -1 : f + 8 * b, 6, -1);
    // same stream with ~30% i_ce duty
    do_reset();
    hold_en = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int v = 1; v <= 8; v++) begin
        for (int g = 0; g < 40 && $urandom_range(99) >= 30; g++) step(0, 99, 1);
        step(1, b == 3 ? 0 : v, b == 0 && v == 1);
      end
    repeat (6) step(1, 0, 0);
    hold_en = 1'b0;
    find_sync(0, f);
    for (int b = 0; b < 3; b++) check_blk($sformatf("gap_b%0d", b), f < 0 ? -1 : f + 8 * b, 6, -1);
    chk("gap_hold", 64'(hold_viol), 64'd0);
    // resync at iaddr=5
    do_reset();
    for (int v = 1; v <= 5; v++) step(1, v, v == 1);
    for (int w = 11; w <= 18; w++) begin
      step(1, w, w == 11);
      if (w == 14) chk("resync_aux_early", 64'(bf.o_bf_aux), 64'd0);
      if (w == 15) begin
        chk("resync_aux", 64'(bf.o_bf_aux), 64'd1);
        chk("resync_left", 64'(bf.o_bf_left), 64'h000B_0000);
        chk("resync_right", 64'(bf.o_bf_right), 64'h000F_0000);
      end
    end
    repeat (20) step(1, 0, 0);
    find_sync(0, f);
    find_sync(f < 0 ? 0 : f + 1, f2);
    chk("resync_partial_sum", 64'(f < 0 ? '0 : samp_q[f]), 64'(mk(6, 0)));
    chk("resync_gap", 64'(f2 - f), 64'd5);
    check_blk("resync_blk", f2, 26, -1);
    // coefficient rotation of pair 2 by j, plus same-cycle write/read
    do_reset();
    i_cw_we = 1'b1; i_cw_addr = 2'd2; i_cw_data = {20'd0, ONE};
    step(0, 0, 0);
    i_cw_we = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      if (v == 7) begin
        i_cw_we = 1'b1; i_cw_addr = 2'd2; i_cw_data = {ONE, 20'd0};
      end
      step(1, v, v == 1);
      i_cw_we = 1'b0;
      if (v == 7) chk("coef_old_on_write", 64'(bf.o_bf_coef), 64'({20'd0, ONE}));
    end
    repeat (20) step(1, 0, 0);
    find_sync(0, f);
    check_blk("coef", f, 6, 6);
    // async reset mid-cycle with i_ce high
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int v = 1; v <= 8; v++) step(1, v, b == 0 && v == 1);
    chk("pre_rst_nonzero", 64'(o_sample != '0), 64'd1);
    i_ce = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("arst_left", 64'(bf.o_bf_left), 64'd0);
    chk("arst_right", 64'(bf.o_bf_right), 64'd0);
    chk("arst_coef", 64'(bf.o_bf_coef), 64'd0);
    chk("arst_sample", 64'(o_sample), 64'd0);
    chk("arst_sync", 64'(o_sync), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    samp_q.delete();
    sync_q.delete();
    for (int v = 0; v < 30; v++) step(1, v + 1, 0);
    ns = 0;
    foreach (sync_q[i]) ns += int'(sync_q[i]);
    chk("arst_no_sync", 64'(ns), 64'd0);
    chk("arst_idle_sample", 64'(o_sample), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
